// File: rtl/posit32_to_float32_if.sv
// Streaming handshake bundle for the posit32 -> binary32 converter.
// The master drives posits in and accepts results; the slave is the converter.
interface posit32_to_float32_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_posit;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_float;
  logic [3:0]  out_flags;

  modport master (
    output in_valid, in_posit, out_ready,
    input  in_ready, out_valid, out_float, out_flags
  );

  modport slave (
    input  in_valid, in_posit, out_ready,
    output in_ready, out_valid, out_float, out_flags
  );
endinterface

// File: rtl/posit32_to_float32.sv
// Three-stage posit32 (es=3) to IEEE-754 binary32 converter.
//   S1: sign/magnitude and regime run length
//   S2: scale = 8r+e, significand alignment (subnormal right shift + sticky)
//   S3: round-to-nearest-even, special cases, packing
// One global advance signal stalls every stage together, so a stalled result
// holds at the output and nothing in flight is lost or duplicated.
module posit32_to_float32 (
  input  logic clk,
  input  logic rst,
  posit32_to_float32_if.slave bus
);

  logic advance;
  logic res_valid;
  logic [31:0] res_float;
  logic [3:0]  res_flags;

  assign advance       = bus.out_ready | ~res_valid;
  assign bus.in_ready  = advance;
  assign bus.out_valid = res_valid;
  assign bus.out_float = res_float;
  assign bus.out_flags = res_flags;

  // ---------------------------------------------------------------- S1
  logic [30:0] mag_d;
  logic [5:0]  run_d;
  logic        run_open;

  // Magnitude: negatives are two's-complemented over the 31 body bits.
  always_comb begin
    mag_d = bus.in_posit[31] ? (~bus.in_posit[30:0] + 31'd1) : bus.in_posit[30:0];
  end

  // Regime run length: count of leading bits equal to the first body bit.
  always_comb begin
    run_d    = 6'd0;
    run_open = 1'b1;
    for (int i = 30; i >= 0; i--) begin
      if (run_open && (mag_d[i] == mag_d[30])) run_d = run_d + 6'd1;
      else run_open = 1'b0;
    end
  end

  logic        s1_valid, s1_sign, s1_nar, s1_zero, s1_rbit;
  logic [30:0] s1_mag;
  logic [5:0]  s1_k;

  // Stage-1 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_nar   <= 1'b0;
      s1_zero  <= 1'b0;
      s1_rbit  <= 1'b0;
      s1_mag   <= '0;
      s1_k     <= '0;
    end else if (advance) begin
      s1_valid <= bus.in_valid;
      s1_sign  <= bus.in_posit[31];
      s1_nar   <= (bus.in_posit == 32'h8000_0000);
      s1_zero  <= (bus.in_posit == 32'h0000_0000);
      s1_rbit  <= mag_d[30];
      s1_mag   <= mag_d;
      s1_k     <= run_d;
    end
  end

  // ---------------------------------------------------------------- S2
  logic signed [9:0] regime, scale;
  logic [30:0] body;
  logic [2:0]  exp_bits;
  logic [28:0] sig, sh_mask;
  logic [4:0]  shamt;
  logic [27:0] m_d;
  logic [7:0]  bexp_d;
  logic        sticky_d, ovf_d, unf_d;

  // Strip regime + terminator (bits past the word end read as 0), then
  // build the scale and align the significand for the normal/subnormal case.
  always_comb begin
    regime   = s1_rbit ? ($signed({4'd0, s1_k}) - 10'sd1) : -$signed({4'd0, s1_k});
    body     = s1_mag << (s1_k + 6'd1);
    exp_bits = body[30:28];
    scale    = (regime <<< 3) + $signed({7'd0, exp_bits});
    sig      = {1'b1, body[27:0]};
    shamt    = 5'(-10'sd126 - scale);
    sh_mask  = (29'd1 << shamt) - 29'd1;
    m_d      = body[27:0];
    bexp_d   = scale[7:0] + 8'd127;
    sticky_d = 1'b0;
    if (scale < -10'sd126) begin
      m_d      = 28'(sig >> shamt);
      bexp_d   = 8'd0;
      sticky_d = |(sig & sh_mask);
    end
    ovf_d = (scale > 10'sd127);
    unf_d = (scale < -10'sd150);
  end

  logic        s2_valid, s2_sign, s2_nar, s2_zero, s2_ovf, s2_unf, s2_sticky;
  logic [27:0] s2_m;
  logic [7:0]  s2_exp;

  // Stage-2 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_nar    <= 1'b0;
      s2_zero   <= 1'b0;
      s2_ovf    <= 1'b0;
      s2_unf    <= 1'b0;
      s2_sticky <= 1'b0;
      s2_m      <= '0;
      s2_exp    <= '0;
    end else if (advance) begin
      s2_valid  <= s1_valid;
      s2_sign   <= s1_sign;
      s2_nar    <= s1_nar;
      s2_zero   <= s1_zero;
      s2_ovf    <= ovf_d;
      s2_unf    <= unf_d;
      s2_sticky <= sticky_d;
      s2_m      <= m_d;
      s2_exp    <= bexp_d;
    end
  end

  // ---------------------------------------------------------------- S3
  logic        guard, sticky, round_up, inexact;
  logic [30:0] packed_v;
  logic [31:0] word_d;
  logic [3:0]  flags_d;

  // RNE on {exp, mantissa}: a mantissa carry ripples into the exponent, which
  // covers both normal renormalisation and subnormal -> 0x00800000 / inf.
  always_comb begin
    guard    = s2_m[4];
    sticky   = (|s2_m[3:0]) | s2_sticky;
    round_up = guard & (sticky | s2_m[5]);
    inexact  = guard | sticky;
    packed_v = {s2_exp, s2_m[27:5]} + {30'd0, round_up};
    word_d   = {s2_sign, packed_v};
    flags_d  = {1'b0, (packed_v[30:23] == 8'hFF),
                inexact & (packed_v[30:23] == 8'h00), inexact};
    if (s2_nar) begin
      word_d  = 32'h7FC0_0000;
      flags_d = 4'b1000;
    end else if (s2_zero) begin
      word_d  = 32'h0000_0000;
      flags_d = 4'b0000;
    end else if (s2_ovf) begin
      word_d  = {s2_sign, 8'hFF, 23'd0};
      flags_d = 4'b0101;
    end else if (s2_unf) begin
      word_d  = {s2_sign, 31'd0};
      flags_d = 4'b0011;
    end
  end

  // Output register; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_float <= '0;
      res_flags <= '0;
    end else if (advance) begin
      res_valid <= s2_valid;
      res_float <= word_d;
      res_flags <= flags_d;
    end
  end

endmodule

// File: tb/tb_posit32_to_float32.sv
// Bench for posit32_to_float32: directed vectors with hand-derived results,
// stall and reset-in-flight scenarios, and a randomized pass against an
// independent rational-decode + RNE model.
module tb_posit32_to_float32;

  logic clk = 1'b0;
  logic rst;

  posit32_to_float32_if bus ();

  posit32_to_float32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] p;
    logic [35:0] x;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] cur_p;
  logic [35:0] cur_exp;
  bit          cur_lat;
  logic [35:0] prev_out;
  bit          prev_stall = 0;
  bit          rnd_done;

  task automatic check_eq(input string tag, input logic [35:0] obs, input logic [35:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference: walk the posit bit by bit, value = M * 2^(scale-nf), then
  // quantise to the binary32 grid with round-half-even.
  function automatic logic [35:0] ref_conv(input logic [31:0] p);
    logic        s, b, inx;
    logic [31:0] a, f;
    int          i, k, e, nf, sc, qe, d;
    longint      m, q, rem, half, w;
    if (p == 32'h0) return 36'h0;
    if (p == 32'h8000_0000) return {4'b1000, 32'h7FC0_0000};
    s = p[31];
    a = s ? (~p + 32'd1) : p;
    b = a[30];
    k = 0;
    i = 30;
    while (i >= 0 && a[i] == b) begin k++; i--; end
    i--;
    e = 0;
    for (int j = 0; j < 3; j++) begin
      e = e * 2 + ((i >= 0) ? int'(a[i]) : 0);
      i--;
    end
    nf = 0;
    m  = 1;
    while (i >= 0) begin m = m * 2 + longint'(a[i]); nf++; i--; end
    sc = (b ? k - 1 : -k) * 8 + e;
    if (sc > 127) return {4'b0101, s, 8'hFF, 23'd0};
    qe = ((sc > -126) ? sc : -126) - 23;
    d  = qe - (sc - nf);
    if (d <= 0) begin
      q = m << (-d);
      inx = 1'b0;
    end else if (d >= 62) begin
      q = 0;
      inx = 1'b1;
    end else begin
      rem  = m & ((longint'(1) << d) - 1);
      q    = m >> d;
      half = longint'(1) << (d - 1);
      inx  = (rem != 0);
      if (rem > half || (rem == half && q[0])) q = q + 1;
    end
    if (sc >= -126) begin
      w = (longint'(sc + 127) << 23) + q - (longint'(1) << 23);
      f = {s, w[30:0]};
    end else begin
      f = {s, q[30:0]};
    end
    return {1'b0, (f[30:23] == 8'hFF), inx && (f[30:23] == 8'h00), inx, f};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard / protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t ent;
    if (rst) begin
      sb.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall)
        check_eq("hold_out", {bus.out_flags, bus.out_float}, prev_out);
      if (bus.out_valid && !bus.out_ready)
        check_eq("stall_in_ready", 36'(bus.in_ready), 36'd0);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check_eq("spurious_out", 36'(bus.out_valid), 36'd0);
        end else begin
          ent = sb.pop_front();
          check_eq($sformatf("conv %h", ent.p), {bus.out_flags, bus.out_float}, ent.x);
          if (ent.lat)
            check_eq($sformatf("latency %h", ent.p), 36'(cyc - ent.cyc), 36'd3);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = {bus.out_flags, bus.out_float};
      if (bus.in_valid && bus.in_ready) begin
        ent.p   = cur_p;
        ent.x   = cur_exp;
        ent.cyc = cyc;
        ent.lat = cur_lat;
        sb.push_back(ent);
      end
    end
  end

  task automatic send(input logic [31:0] p, input logic [35:0] x, input bit lat);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_posit = p;
    cur_p   = p;
    cur_exp = x;
    cur_lat = lat;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_eq("send_timeout", 36'(bus.in_ready), 36'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam int ND = 19;
  logic [31:0] dir_p[ND];
  logic [35:0] dir_x[ND];

  initial begin
    logic [31:0] rp;
    int t;

    dir_p = '{32'h4000_0000, 32'hC000_0000, 32'h4800_0000, 32'h4000_0007,
              32'h4000_0004, 32'h4000_000C, 32'h7FFF_FFFF, 32'h0000_0001,
              32'h8000_0000, 32'h0000_0000, 32'h8000_0001, 32'h0000_1001,
              32'h0000_4001, 32'h0000_0A00, 32'h0000_0A01, 32'h7FFF_BFFF,
              32'h7FFF_C000, 32'hFFFF_FFFF, 32'h3FFF_FFFF};
    dir_x = '{{4'h0, 32'h3F80_0000}, {4'h0, 32'hBF80_0000}, {4'h0, 32'h4080_0000},
              {4'h1, 32'h3F80_0001}, {4'h1, 32'h3F80_0000}, {4'h1, 32'h3F80_0002},
              {4'h5, 32'h7F80_0000}, {4'h3, 32'h0000_0000}, {4'h8, 32'h7FC0_0000},
              {4'h0, 32'h0000_0000}, {4'h5, 32'hFF80_0000}, {4'h3, 32'h0000_0020},
              {4'h0, 32'h0020_0400}, {4'h3, 32'h0000_0000}, {4'h3, 32'h0000_0001},
              {4'h0, 32'h7F7F_F000}, {4'h5, 32'h7F80_0000}, {4'h3, 32'h8000_0000},
              {4'h1, 32'h3F80_0000}};

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_posit = 32'h0;
    bus.out_ready = 1'b1;
    cur_p = 0; cur_exp = 0; cur_lat = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_out_valid", 36'(bus.out_valid), 36'd0);
    check_eq("reset_out_word", {bus.out_flags, bus.out_float}, 36'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("in_ready_after_reset", 36'(bus.in_ready), 36'd1);
    @(posedge clk);
    #1;

    // Back-to-back directed vectors with exact 3-cycle latency.
    for (int i = 0; i < ND; i++) send(dir_p[i], dir_x[i], 1'b1);
    idle(8);

    // 8-word stream with a 4-cycle consumer stall in the middle.
    fork
      begin
        for (int i = 0; i < 8; i++) send(dir_p[i + 3], dir_x[i + 3], 1'b0);
        idle(1);
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    idle(10);

    // Three words in flight (output stalled), then a reset pulse.
    bus.out_ready = 1'b0;
    send(32'h4000_0000, {4'h0, 32'h3F80_0000}, 1'b0);
    send(32'h4800_0000, {4'h0, 32'h4080_0000}, 1'b0);
    send(32'hC000_0000, {4'h0, 32'hBF80_0000}, 1'b0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_flush_valid", 36'(bus.out_valid), 36'd0);
    check_eq("rst_flush_word", {bus.out_flags, bus.out_float}, 36'd0);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    send(32'h4800_0000, {4'h0, 32'h4080_0000}, 1'b1);
    idle(8);

    // Randomized words against the model, with a randomly stalling consumer.
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          rp = $urandom;
          if (i % 2 == 1) rp = rp >> $urandom_range(0, 31);
          if (i % 4 == 3) rp = ~rp + 32'd1;
          send(rp, ref_conv(rp), 1'b0);
        end
        idle(1);
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join

    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    check_eq("drain", 36'(sb.size()), 36'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
